eth_rx_frame_meter: RTL and testbench
=====================================

Name: eth_rx_frame_meter

Overview:
- AXI-Stream pass-through stage between the RX CDC FIFO output and the iDMA AXIS read port, in the system clock domain.
- Counts payload bytes of each received Ethernet frame using tkeep and tlast, and pushes one length entry per frame into a small first-word-fall-through (FWFT) length FIFO.
- Software or the descriptor logic reads that FIFO to program the iDMA transfer length for each frame.
- Adds exactly one register stage on the data path.

Parameters:
- DataWidth, 32, stream data width in bits; multiple of 8.
- LenWidth, 16, width of the frame length field in bytes.
- LenFifoDepth, 4, number of length entries; minimum 2.
- MaxFrameBytes, 1518, frames longer than this set the oversize flag.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset.
- s_tdata_i  in  DataWidth  upstream data.
- s_tkeep_i  in  DataWidth/8  upstream byte enables.
- s_tlast_i  in  1  upstream end of frame.
- s_tvalid_i  in  1  upstream valid.
- s_tready_o  out  1  upstream ready.
- m_tdata_o  out  DataWidth  downstream data, to iDMA.
- m_tkeep_o  out  DataWidth/8  downstream byte enables.
- m_tlast_o  out  1  downstream end of frame.
- m_tvalid_o  out  1  downstream valid.
- m_tready_i  in  1  downstream ready.
- len_o  out  LenWidth  head-of-FIFO frame length in bytes.
- len_oversize_o  out  1  head entry exceeded MaxFrameBytes.
- len_valid_o  out  1  length FIFO not empty.
- len_ready_i  in  1  pop the head entry.
- len_count_o  out  $clog2(LenFifoDepth+1)  number of entries held.
- irq_en_i  in  1  interrupt enable; present only with the optional feature.
- irq_o  out  1  frame-available interrupt; present only with the optional feature.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - m_tvalid_o=0; m_tdata_o, m_tkeep_o and m_tlast_o=0.
  - Byte counter=0, oversize sticky=0.
  - Length FIFO empty: len_valid_o=0, len_count_o=0, len_o=0, len_oversize_o=0, irq_o=0.
- Data register stage:
  - s_tready_o = (!m_tvalid_o || m_tready_i) && !fifo_full.
  - fifo_full is registered state.
  - s_tready_o does not depend on s_tvalid_i.
  - A beat is accepted when s_tvalid_i && s_tready_o. On acceptance, data, keep and last are loaded into the output register and m_tvalid_o=1 on the next cycle (latency 1).
  - If m_tready_i && m_tvalid_o and no new beat is accepted, m_tvalid_o drops to 0.
  - Data is never modified or dropped.
  - Holding m_tvalid_o with m_tready_i=0 keeps the output stable.
- Byte counting:
  - On each accepted beat, sum = cnt + popcount(s_tkeep_i). The addition is LenWidth+1 bits wide.
  - tkeep is not required to be contiguous; a beat with tkeep=0 contributes 0.
  - The counter saturates at 2^LenWidth-1.
  - The oversize sticky bit is set when sum > MaxFrameBytes; it is evaluated on every beat of the frame.
  - On a beat with tlast: push {oversize_sticky | (sum>MaxFrameBytes), saturated sum} into the length FIFO, then clear cnt and the sticky bit in the same cycle. Otherwise cnt <= saturated sum.
- Length FIFO (FWFT):
  - len_valid_o = !empty.
  - Pop when len_valid_o && len_ready_i.
  - Push and pop in the same cycle: the count is unchanged and the pointers both advance.
  - A push cannot occur while full, because s_tready_o is 0.
  - A pop while full reopens s_tready_o on the next cycle.
  - Pointers wrap modulo LenFifoDepth.
  - len_o and len_oversize_o hold 0 when empty.
- Full-FIFO stall: while fifo_full, every beat stalls, including mid-frame beats, so no frame can complete without a slot.
- Reset mid-frame: the partial count is discarded, all FIFO entries are lost, and the output register is invalidated. The next beat after reset starts a new count from 0.

Optional Feature:
- Macro: ETH_RX_FRAME_METER_IRQ_EN.
- When defined:
  - Ports irq_en_i and irq_o exist.
  - irq_o is registered: irq_o <= irq_en_i && (next-state FIFO count != 0). This is a level, asserted the cycle after the first push and cleared the cycle after the last pop.
- When undefined:
  - Neither port exists and no interrupt logic is generated.

Test Plan:
- 16 beats, tkeep=0xF, tlast on beat 16, m_tready_i=1 -> m stream identical with 1-cycle latency; one entry len_o=64, len_oversize_o=0, len_count_o=1.
- 16 beats where the last has tkeep=0x1, followed by a single-beat frame with tkeep=0x3 -> entries 61 then 2, in order; pop both -> len_valid_o=0.
- 380 beats with tkeep=0xF (1520 bytes) -> len_o=1520, len_oversize_o=1; next frame of 64 bytes -> oversize=0 (sticky cleared).
- LenFifoDepth=4, len_ready_i=0, five 8-byte frames -> s_tready_o=0 from the cycle after the 4th tlast; pulse len_ready_i once -> s_tready_o=1 next cycle, 5th frame completes, len_count_o=4.
- m_tready_i toggling 1/0 each cycle during a 64-byte frame -> no beat lost or duplicated; m_tdata_o stable while stalled; length entry = 64.
- Reset asserted for 1 cycle after beat 5 of a frame -> all outputs return to reset values; a following 12-byte frame gives len_o=12. With ETH_RX_FRAME_METER_IRQ_EN and irq_en_i=1, irq_o=1 the cycle after the push and 0 the cycle after the pop.

Source files
------------

// File: rtl/eth_rx_frame_meter.sv
// AXI-Stream register slice that measures each frame's byte length into a small FWFT length FIFO.
// Define ETH_RX_FRAME_METER_IRQ_EN to add the irq_en_i/irq_o frame-available interrupt.
module eth_rx_frame_meter #(
    parameter int DataWidth     = 32,
    parameter int LenWidth      = 16,
    parameter int LenFifoDepth  = 4,
    parameter int MaxFrameBytes = 1518
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [DataWidth-1:0]                 s_tdata_i,
    input  logic [DataWidth/8-1:0]               s_tkeep_i,
    input  logic                                 s_tlast_i,
    input  logic                                 s_tvalid_i,
    output logic                                 s_tready_o,
    output logic [DataWidth-1:0]                 m_tdata_o,
    output logic [DataWidth/8-1:0]               m_tkeep_o,
    output logic                                 m_tlast_o,
    output logic                                 m_tvalid_o,
    input  logic                                 m_tready_i,
    output logic [LenWidth-1:0]                  len_o,
    output logic                                 len_oversize_o,
    output logic                                 len_valid_o,
    input  logic                                 len_ready_i,
`ifdef ETH_RX_FRAME_METER_IRQ_EN
    output logic [$clog2(LenFifoDepth+1)-1:0]    len_count_o,
    input  logic                                 irq_en_i,
    output logic                                 irq_o
`else
    output logic [$clog2(LenFifoDepth+1)-1:0]    len_count_o
`endif
);

    localparam int KeepWidth = DataWidth / 8;
    localparam int PopWidth  = $clog2(KeepWidth + 1);
    localparam int CntWidth  = $clog2(LenFifoDepth + 1);
    localparam int PtrWidth  = $clog2(LenFifoDepth);
    localparam logic [LenWidth:0]   MaxBytes  = (LenWidth+1)'(MaxFrameBytes);
    localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(LenFifoDepth - 1);
    localparam logic [CntWidth-1:0] FullCount = CntWidth'(LenFifoDepth);

    logic                  m_tvalid_q, m_tvalid_d;
    logic [DataWidth-1:0]  m_tdata_q, m_tdata_d;
    logic [KeepWidth-1:0]  m_tkeep_q, m_tkeep_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [LenWidth-1:0]   cnt_q, cnt_d;
    logic                  over_q, over_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic [LenWidth:0]     fifo_mem_q [LenFifoDepth];

    logic                  accept, push, pop;
    logic [PopWidth-1:0]   popcnt;
    logic [LenWidth:0]     sum;
    logic [LenWidth-1:0]   sum_sat;
    logic                  sum_over;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Ready is deliberately independent of s_tvalid_i; a full length FIFO stalls every beat.
    assign s_tready_o = (!m_tvalid_q || m_tready_i) && !full_q;
    assign accept     = s_tvalid_i && s_tready_o;
    assign push       = accept && s_tlast_i;
    assign pop        = len_valid_o && len_ready_i;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < KeepWidth; i++) begin
            popcnt = popcnt + PopWidth'(s_tkeep_i[i]);
        end
        sum      = {1'b0, cnt_q} + (LenWidth+1)'(popcnt);
        sum_sat  = sum[LenWidth] ? '1 : sum[LenWidth-1:0];
        sum_over = sum > MaxBytes;
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        cnt_d      = cnt_q;
        over_d     = over_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q;

        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_tdata_i;
            m_tkeep_d  = s_tkeep_i;
            m_tlast_d  = s_tlast_i;
            if (s_tlast_i) begin
                cnt_d  = '0;
                over_d = 1'b0;
            end else begin
                cnt_d  = sum_sat;
                over_d = over_q | sum_over;
            end
        end else if (m_tready_i) begin
            m_tvalid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == FullCount);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            cnt_q      <= '0;
            over_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            cnt_q      <= cnt_d;
            over_q     <= over_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {over_q | sum_over, sum_sat};
        end
    end

    assign m_tvalid_o  = m_tvalid_q;
    assign m_tdata_o   = m_tdata_q;
    assign m_tkeep_o   = m_tkeep_q;
    assign m_tlast_o   = m_tlast_q;
    assign len_valid_o = (count_q != '0);
    assign len_count_o = count_q;
    assign {len_oversize_o, len_o} = len_valid_o ? fifo_mem_q[rd_ptr_q] : '0;

`ifdef ETH_RX_FRAME_METER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en_i && (count_d != '0);
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_meter.sv
// Self-checking bench for eth_rx_frame_meter: directed frames plus randomized traffic
// compared every cycle against a queue-based model of the stream and length FIFO.
module tb_eth_rx_frame_meter;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int LW    = 16;
    localparam int Depth = 4;
    localparam int MaxB  = 1518;
    localparam int CW    = $clog2(Depth + 1);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] s_tdata_i;
    logic [KW-1:0] s_tkeep_i;
    logic          s_tlast_i;
    logic          s_tvalid_i;
    logic          s_tready_o;
    logic [DW-1:0] m_tdata_o;
    logic [KW-1:0] m_tkeep_o;
    logic          m_tlast_o;
    logic          m_tvalid_o;
    logic          m_tready_i;
    logic [LW-1:0] len_o;
    logic          len_oversize_o;
    logic          len_valid_o;
    logic          len_ready_i;
    logic [CW-1:0] len_count_o;
`ifdef ETH_RX_FRAME_METER_IRQ_EN
    logic          irq_en_i;
    logic          irq_o;
    logic          expIrq;
`endif

    always #5 clk = ~clk;

    eth_rx_frame_meter #(
        .DataWidth    (DW),
        .LenWidth     (LW),
        .LenFifoDepth (Depth),
        .MaxFrameBytes(MaxB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .s_tdata_i     (s_tdata_i),
        .s_tkeep_i     (s_tkeep_i),
        .s_tlast_i     (s_tlast_i),
        .s_tvalid_i    (s_tvalid_i),
        .s_tready_o    (s_tready_o),
        .m_tdata_o     (m_tdata_o),
        .m_tkeep_o     (m_tkeep_o),
        .m_tlast_o     (m_tlast_o),
        .m_tvalid_o    (m_tvalid_o),
        .m_tready_i    (m_tready_i),
        .len_o         (len_o),
        .len_oversize_o(len_oversize_o),
        .len_valid_o   (len_valid_o),
        .len_ready_i   (len_ready_i),
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        .len_count_o   (len_count_o),
        .irq_en_i      (irq_en_i),
        .irq_o         (irq_o)
`else
        .len_count_o   (len_count_o)
`endif
    );

    // Reference model: beats in flight to the sink, and completed frame lengths awaiting a pop.
    logic [DW+KW:0] sentQ[$];
    logic [LW:0]    lenQ[$];
    int             frameBytes = 0;
    int             checkCount = 0;
    int             passCount  = 0;
    bit             toggleReady = 1'b0;
    bit             randomMode  = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        sentQ.delete();
        lenQ.delete();
        frameBytes = 0;
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        expIrq = 1'b0;
`endif
    endtask

    // One clock: check every observable output against the model, then advance the model.
    task automatic cycle(output bit accepted);
        logic expReady;
        bit   outHs;
        bit   popLen;
        int   lenSat;
        if (toggleReady) m_tready_i = ~m_tready_i;
        if (randomMode) begin
            m_tready_i  = ($urandom_range(0, 3) != 0);
            len_ready_i = ($urandom_range(0, 2) == 0);
        end
        #2;
        expReady = (sentQ.size() == 0 || m_tready_i) && (lenQ.size() < Depth);
        checkOutput("s_tready", 64'(s_tready_o), 64'(expReady));
        checkOutput("m_tvalid", 64'(m_tvalid_o), 64'(sentQ.size() != 0));
        if (sentQ.size() != 0)
            checkOutput("m_beat", 64'({m_tlast_o, m_tkeep_o, m_tdata_o}), 64'(sentQ[0]));
        checkOutput("len_valid", 64'(len_valid_o), 64'(lenQ.size() != 0));
        checkOutput("len_count", 64'(len_count_o), 64'(lenQ.size()));
        checkOutput("len_head", 64'({len_oversize_o, len_o}), (lenQ.size() != 0) ? 64'(lenQ[0]) : 64'd0);
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        checkOutput("irq", 64'(irq_o), 64'(expIrq));
`endif
        outHs    = (sentQ.size() != 0) && m_tready_i;
        popLen   = (lenQ.size() != 0) && len_ready_i;
        accepted = s_tvalid_i && expReady;
        if (outHs) void'(sentQ.pop_front());
        if (popLen) void'(lenQ.pop_front());
        if (accepted) begin
            sentQ.push_back({s_tlast_i, s_tkeep_i, s_tdata_i});
            frameBytes += $countones(s_tkeep_i);
            if (s_tlast_i) begin
                lenSat = (frameBytes > 65535) ? 65535 : frameBytes;
                lenQ.push_back({frameBytes > MaxB, LW'(lenSat)});
                frameBytes = 0;
            end
        end
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        expIrq = irq_en_i && (lenQ.size() != 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        s_tvalid_i = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc;
        int guard;
        guard      = 0;
        s_tvalid_i = 1'b1;
        s_tdata_i  = d;
        s_tkeep_i  = k;
        s_tlast_i  = l;
        do begin
            cycle(acc);
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            checkCount++;
            $error("[TB] FAIL accept_timeout: observed no handshake expected handshake within 200 cycles");
        end
        s_tvalid_i = 1'b0;
    endtask

    task automatic sendFrame(input int beats, input logic [KW-1:0] lastKeep, input bit randKeep);
        logic [KW-1:0] k;
        for (int i = 0; i < beats; i++) begin
            k = randKeep ? KW'($urandom) : {KW{1'b1}};
            applyStimulus($urandom, (i == beats - 1) ? lastKeep : k, i == beats - 1);
        end
    endtask

    task automatic resetDut();
        rst_ni      = 1'b0;
        s_tvalid_i  = 1'b0;
        len_ready_i = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("rst_m_tvalid", 64'(m_tvalid_o), 64'd0);
        checkOutput("rst_m_beat", 64'({m_tlast_o, m_tkeep_o, m_tdata_o}), 64'd0);
        checkOutput("rst_len_valid", 64'(len_valid_o), 64'd0);
        checkOutput("rst_len_count", 64'(len_count_o), 64'd0);
        checkOutput("rst_len_head", 64'({len_oversize_o, len_o}), 64'd0);
        checkOutput("rst_s_tready", 64'(s_tready_o), 64'd1);
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        checkOutput("rst_irq", 64'(irq_o), 64'd0);
`endif
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit            acc;
        logic [DW-1:0] stalledData;
        rst_ni      = 1'b0;
        s_tdata_i   = '0;
        s_tkeep_i   = '0;
        s_tlast_i   = 1'b0;
        s_tvalid_i  = 1'b0;
        m_tready_i  = 1'b0;
        len_ready_i = 1'b0;
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        irq_en_i    = 1'b1;
        expIrq      = 1'b0;
`endif
        @(posedge clk);
        #1;
        resetDut();

        // Full-width 64-byte frame through a free-flowing sink.
        m_tready_i = 1'b1;
        sendFrame(16, 4'hF, 1'b0);
        idle(2);
        checkOutput("t1_len", 64'(len_o), 64'd64);
        checkOutput("t1_oversize", 64'(len_oversize_o), 64'd0);
        checkOutput("t1_count", 64'(len_count_o), 64'd1);
        len_ready_i = 1'b1;
        idle(1);
        len_ready_i = 1'b0;
        checkOutput("t1_popped", 64'(len_valid_o), 64'd0);

        // Partial last beat, then a single-beat frame; entries come out in order.
        sendFrame(16, 4'h1, 1'b0);
        sendFrame(1, 4'h3, 1'b0);
        idle(2);
        checkOutput("t2_len_first", 64'(len_o), 64'd61);
        checkOutput("t2_count", 64'(len_count_o), 64'd2);
        len_ready_i = 1'b1;
        idle(1);
        checkOutput("t2_len_second", 64'(len_o), 64'd2);
        idle(1);
        len_ready_i = 1'b0;
        checkOutput("t2_empty", 64'(len_valid_o), 64'd0);

        // Oversize frame, then a normal frame proving the sticky bit cleared.
        sendFrame(380, 4'hF, 1'b0);
        sendFrame(16, 4'hF, 1'b0);
        idle(2);
        checkOutput("t3_len_big", 64'(len_o), 64'd1520);
        checkOutput("t3_oversize_big", 64'(len_oversize_o), 64'd1);
        len_ready_i = 1'b1;
        idle(1);
        len_ready_i = 1'b0;
        checkOutput("t3_len_small", 64'(len_o), 64'd64);
        checkOutput("t3_oversize_small", 64'(len_oversize_o), 64'd0);
        len_ready_i = 1'b1;
        idle(1);
        len_ready_i = 1'b0;

        // Fill the length FIFO; the fifth frame must stall until one pop frees a slot.
        for (int f = 0; f < 4; f++) sendFrame(2, 4'hF, 1'b0);
        checkOutput("t4_full_count", 64'(len_count_o), 64'd4);
        checkOutput("t4_stall_ready", 64'(s_tready_o), 64'd0);
        stalledData = $urandom;
        s_tvalid_i  = 1'b1;
        s_tdata_i   = stalledData;
        s_tkeep_i   = 4'hF;
        s_tlast_i   = 1'b0;
        for (int i = 0; i < 3; i++) cycle(acc);
        checkOutput("t4_still_stalled", 64'(s_tready_o), 64'd0);
        len_ready_i = 1'b1;
        cycle(acc);
        len_ready_i = 1'b0;
        checkOutput("t4_reopen", 64'(s_tready_o), 64'd1);
        applyStimulus(stalledData, 4'hF, 1'b0);
        applyStimulus($urandom, 4'hF, 1'b1);
        idle(2);
        checkOutput("t4_count_after", 64'(len_count_o), 64'd4);
        len_ready_i = 1'b1;
        idle(4);
        len_ready_i = 1'b0;
        checkOutput("t4_drained", 64'(len_valid_o), 64'd0);

        // Sink backpressure alternating every cycle.
        toggleReady = 1'b1;
        sendFrame(16, 4'hF, 1'b0);
        idle(2);
        toggleReady = 1'b0;
        m_tready_i  = 1'b1;
        idle(2);
        checkOutput("t5_len", 64'(len_o), 64'd64);
        len_ready_i = 1'b1;
        idle(1);
        len_ready_i = 1'b0;

        // Randomized frames, sparse keeps and random sink/pop readiness.
        randomMode = 1'b1;
        for (int f = 0; f < 8; f++) sendFrame($urandom_range(1, 20), KW'($urandom), 1'b1);
        randomMode  = 1'b0;
        m_tready_i  = 1'b1;
        len_ready_i = 1'b1;
        idle(8);
        len_ready_i = 1'b0;
        checkOutput("rand_drained", 64'(len_valid_o), 64'd0);

        // Reset in the middle of a frame discards the partial count.
        for (int i = 0; i < 5; i++) applyStimulus($urandom, 4'hF, 1'b0);
        resetDut();
        m_tready_i = 1'b1;
        sendFrame(3, 4'hF, 1'b0);
        idle(2);
        checkOutput("t6_len", 64'(len_o), 64'd12);
        checkOutput("t6_oversize", 64'(len_oversize_o), 64'd0);
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        checkOutput("t6_irq_set", 64'(irq_o), 64'd1);
`endif
        len_ready_i = 1'b1;
        idle(1);
        len_ready_i = 1'b0;
`ifdef ETH_RX_FRAME_METER_IRQ_EN
        checkOutput("t6_irq_clear", 64'(irq_o), 64'd0);
`endif
        checkOutput("t6_empty", 64'(len_valid_o), 64'd0);
        idle(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
